// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter: FSM encoding, idle bus
// levels and the select-index width (sized for the largest supported NUM_REQ).
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;

   localparam logic       SCL_IDLE   = 1'b1;
   localparam logic       SDA_IDLE   = 1'b1;
   localparam logic [7:0] STATE_NONE = 8'd0;

   localparam int MAX_REQ = 8;
   localparam int IDX_W   = $clog2(MAX_REQ);

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Engine-side and bus-side signal bundle of the I2C bus arbiter.
// slave = arbiter view, master = engines/top-level view.
interface i2c_bus_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   done;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   scl_in;
   logic [NUM_REQ-1:0]   sda_in;
   logic [8*NUM_REQ-1:0] state_in;
   logic [NUM_REQ-1:0]   ack_in;
   logic [NUM_REQ-1:0]   err_in;
   logic                 SCL;
   logic                 SDA;
   logic [7:0]           State;
   logic                 ACK_bit;
   logic                 error_bit;
   logic                 busy;
   logic                 timeout;

   modport slave (
      input  req, done, scl_in, sda_in, state_in, ack_in, err_in,
      output grant, SCL, SDA, State, ACK_bit, error_bit, busy, timeout
   );

   modport master (
      output req, done, scl_in, sda_in, state_in, ack_in, err_in,
      input  grant, SCL, SDA, State, ACK_bit, error_bit, busy, timeout
   );
endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around past NUM_REQ-1.
module rr_pick
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [MAX_REQ-1:0] req_pad;
   assign req_pad = MAX_REQ'(req_i);

   // Walk from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      int j;
      j       = 0;
      valid_o = |req_i;
      idx_o   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_pad[j[IDX_W-1:0]]) idx_o = j[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C bus between NUM_REQ engines, with a
// bus-free gap after each grant. Watchdog compiled in with I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                FSM_Clk,
   input  logic                reset,
   i2c_bus_arbiter_if.slave    bus
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    sel_q, sel_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                scl_q, scl_d;
   logic                sda_q, sda_d;
   logic [7:0]          st_q, st_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                to_q, to_d;
`endif

   logic [MAX_REQ-1:0]   req_pad, done_pad, scl_pad, sda_pad, ack_pad, err_pad;
   logic [8*MAX_REQ-1:0] st_pad;
   logic                 pick_vld;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     sel_inc;
   logic                 exit_c;

   assign req_pad  = MAX_REQ'(bus.req);
   assign done_pad = MAX_REQ'(bus.done);
   assign scl_pad  = MAX_REQ'(bus.scl_in);
   assign sda_pad  = MAX_REQ'(bus.sda_in);
   assign ack_pad  = MAX_REQ'(bus.ack_in);
   assign err_pad  = MAX_REQ'(bus.err_in);
   assign st_pad   = (8*MAX_REQ)'(bus.state_in);
   assign sel_inc  = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .valid_o (pick_vld),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge FSM_Clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         scl_q   <= SCL_IDLE;
         sda_q   <= SDA_IDLE;
         st_q    <= STATE_NONE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         gap_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
         st_q    <= st_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         gap_q   <= gap_d;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         to_q    <= to_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      scl_d   = scl_q;
      sda_d   = sda_q;
      st_d    = st_q;
      ack_d   = ack_q;
      err_d   = err_q;
      gap_d   = gap_q;
      exit_c  = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = to_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            scl_d = SCL_IDLE;
            sda_d = SDA_IDLE;
            st_d  = STATE_NONE;
            if (pick_vld) begin
               sel_d   = pick_idx;
               grant_d = NUM_REQ'(1) << pick_idx;
               state_d = ARB_GRANT;
`ifdef I2C_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB_GRANT: begin
            scl_d = scl_pad[sel_q];
            sda_d = sda_pad[sel_q];
            st_d  = st_pad[{sel_q, 3'b000} +: 8];
            ack_d = ack_pad[sel_q];
            err_d = err_pad[sel_q];
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            // done beats abort, which beats the watchdog
            if (done_pad[sel_q]) begin
               exit_c = 1'b1;
            end else if (!req_pad[sel_q]) begin
               exit_c = 1'b1;
               err_d  = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               exit_c = 1'b1;
               err_d  = 1'b1;
               to_d   = 1'b1;
`endif
            end
            if (exit_c) begin
               grant_d = '0;
               ptr_d   = sel_inc;
               gap_d   = '0;
               scl_d   = SCL_IDLE;
               sda_d   = SDA_IDLE;
               st_d    = STATE_NONE;
               state_d = ARB_GAP;
            end
         end
         ARB_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ARB_IDLE;
            else                                  gap_d   = gap_q + 1'b1;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign bus.grant     = grant_q;
   assign bus.SCL       = scl_q;
   assign bus.SDA       = sda_q;
   assign bus.State     = st_q;
   assign bus.ACK_bit   = ack_q;
   assign bus.error_bit = err_q;
   assign bus.busy      = (state_q != ARB_IDLE);
`ifdef I2C_ARB_TIMEOUT_EN
   assign bus.timeout   = to_q;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized engine traffic against a per-cycle reference model; expected
// bus outputs are queued by the model and popped by an independent monitor.
module tb_i2c_bus_arbiter;

   localparam int N   = 2;
   localparam int GAP = 4;
   localparam int TO  = 16;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic FSM_Clk = 1'b0;
   logic reset;
   always #5 FSM_Clk = ~FSM_Clk;

   i2c_bus_arbiter_if #(.NUM_REQ(N)) bus ();

   i2c_bus_arbiter #(
      .NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .FSM_Clk (FSM_Clk),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct packed {
      logic [N-1:0] grant;
      logic         scl;
      logic         sda;
      logic [7:0]   st;
      logic         ack;
      logic         err;
      logic         busy;
      logic         to;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference model: who owns the bus, how much bus-free time remains,
   // where the rotation resumes, and how long the current owner has held it.
   initial begin
      int   owner, gap_left, ptr, age;
      obs_t m;
      owner = -1; gap_left = 0; ptr = 0; age = 0;
      m = '{grant: '0, scl: 1'b1, sda: 1'b1, st: 8'd0, ack: 1'b0, err: 1'b0, busy: 1'b0, to: 1'b0};
      forever begin
         @(posedge FSM_Clk);
         if (reset) begin
            owner = -1; gap_left = 0; ptr = 0; age = 0;
            m = '{grant: '0, scl: 1'b1, sda: 1'b1, st: 8'd0, ack: 1'b0, err: 1'b0, busy: 1'b0, to: 1'b0};
         end else if (owner >= 0) begin
            int o;
            bit fin, bad;
            o = owner; fin = 1'b0; bad = 1'b0;
            if (bus.done[o]) fin = 1'b1;
            else if (!bus.req[o]) begin fin = 1'b1; bad = 1'b1; end
            else if (TO_EN && age == TO - 1) begin fin = 1'b1; bad = 1'b1; m.to = 1'b1; end
            m.ack = bus.ack_in[o];
            m.err = bus.err_in[o] | bad;
            if (fin) begin
               owner = -1; gap_left = GAP; ptr = (o + 1) % N;
               m.grant = '0; m.scl = 1'b1; m.sda = 1'b1; m.st = 8'd0;
            end else begin
               age++;
               m.scl = bus.scl_in[o];
               m.sda = bus.sda_in[o];
               m.st  = bus.state_in[8*o +: 8];
            end
         end else if (gap_left > 0) begin
            gap_left--;
         end else begin
            for (int k = 0; k < N; k++)
               if (owner < 0 && bus.req[(ptr + k) % N]) owner = (ptr + k) % N;
            if (owner >= 0) begin
               age = 0;
               m.grant = '0;
               m.grant[owner] = 1'b1;
            end
         end
         m.busy = (owner >= 0) || (gap_left > 0);
         exp_q.push_back(m);
      end
   end

   // Monitor: compare every registered output set shortly after each edge.
   initial begin
      obs_t a, e;
      forever begin
         @(posedge FSM_Clk);
         #1;
         cycle++;
         a = {bus.grant, bus.SCL, bus.SDA, bus.State, bus.ACK_bit,
              bus.error_bit, bus.busy, bus.timeout};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty cyc%0d no expected entry queued", cycle);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL bus_out cyc%0d got g=%b scl=%b sda=%b st=%h ack=%b err=%b busy=%b to=%b exp g=%b scl=%b sda=%b st=%h ack=%b err=%b busy=%b to=%b",
                        cycle, a.grant, a.scl, a.sda, a.st, a.ack, a.err, a.busy, a.to,
                        e.grant, e.scl, e.sda, e.st, e.ack, e.err, e.busy, e.to);
            end
         end
      end
   end

   // Engine behaviour: random requests, spurious done from idle engines,
   // and owners that finish with done, abort by dropping req, or stall.
   initial begin
      int gage[N];
      int gtgt[N];
      for (int i = 0; i < N; i++) begin gage[i] = 0; gtgt[i] = 0; end
      reset        = 1'b1;
      bus.req      = '0;
      bus.done     = '0;
      bus.scl_in   = '1;
      bus.sda_in   = '1;
      bus.state_in = '0;
      bus.ack_in   = '0;
      bus.err_in   = '0;
      repeat (3) @(negedge FSM_Clk);
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge FSM_Clk);
         reset        = ($urandom_range(0, 399) == 0);
         bus.done     = '0;
         bus.scl_in   = N'($urandom);
         bus.sda_in   = N'($urandom);
         bus.state_in = (8*N)'($urandom);
         bus.ack_in   = N'($urandom);
         bus.err_in   = N'($urandom);
         for (int i = 0; i < N; i++) begin
            if (bus.grant[i]) begin
               if (gage[i] == 0) gtgt[i] = $urandom_range(0, 22);
               if (gage[i] == gtgt[i]) begin
                  if ($urandom_range(0, 4) == 0) bus.req[i] = 1'b0;
                  else                           bus.done[i] = 1'b1;
               end
               gage[i]++;
            end else begin
               gage[i] = 0;
               if (!bus.req[i])                    bus.req[i] = ($urandom_range(0, 2) == 0);
               else if ($urandom_range(0, 19) == 0) bus.req[i] = 1'b0;
               bus.done[i] = ($urandom_range(0, 9) == 0);
            end
         end
      end
      repeat (3) @(negedge FSM_Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
